// File: rtl/led_pattern_gen.sv
// LED pattern engine: four run-time selectable modes (alternate, chase, binary count, PWM breathe)
// with two debounced push buttons that cycle the mode and the step rate.

module led_btn_debounce #(
  parameter int CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);

  logic          meta_r;
  logic          sync_r;
  logic          level_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  // Accept a new level on the cycle the synced input has disagreed with it for CYCLES cycles.
  always_comb begin
    accept_s = (sync_r != level_r) && (cnt_r == CW'(CYCLES - 1));
    press    = accept_s && sync_r;
  end

  // Synchroniser, stability counter and debounced level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_r  <= 1'b0;
      sync_r  <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      meta_r <= btn;
      sync_r <= meta_r;
      if (accept_s) begin
        level_r <= sync_r;
        cnt_r   <= {CW{1'b0}};
      end else if (sync_r != level_r) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end
endmodule

module led_pattern_gen #(
  parameter int NUM_LEDS        = 4,
  parameter int STEP_DIV        = 25000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PWM_BITS        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_mode,
  input  logic                btn_speed,
  output logic [NUM_LEDS-1:0] leds,
  output logic [1:0]          mode
);
  localparam int PW = $clog2(STEP_DIV + 1);
  localparam logic [PW-1:0] STEP_DIV_L = PW'(STEP_DIV);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  localparam logic [1:0] MODE_ALT     = 2'd0;
  localparam logic [1:0] MODE_CHASE   = 2'd1;
  localparam logic [1:0] MODE_COUNT   = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

  logic [1:0]          mode_r;
  logic [1:0]          speed_r;
  logic [PW-1:0]       presc_r;
  logic [PWM_BITS-1:0] duty_r;
  logic                dir_up_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [NUM_LEDS-1:0] leds_r;

  logic          mode_press_s;
  logic          speed_press_s;
  logic [PW-1:0] limit_s;
  logic          tick_s;
  logic [1:0]    next_mode_s;

  function automatic logic [NUM_LEDS-1:0] seed_for(input logic [1:0] m);
    logic [NUM_LEDS-1:0] s;
    s = {NUM_LEDS{1'b0}};
    case (m)
      MODE_ALT: begin
        for (int i = 0; i < NUM_LEDS; i++) s[i] = (i % 2 == 0);
      end
      MODE_CHASE:   s[0] = 1'b1;
      MODE_COUNT:   s = {NUM_LEDS{1'b0}};
      MODE_BREATHE: s = {NUM_LEDS{1'b0}};
      default:      s = {NUM_LEDS{1'b0}};
    endcase
    return s;
  endfunction

  led_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_mode),
    .press (mode_press_s)
  );

  led_btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb_speed (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_speed),
    .press (speed_press_s)
  );

  // A press clears the prescaler, so it also swallows a step that would land on the same cycle.
  always_comb begin
    limit_s     = STEP_DIV_L >> speed_r;
    tick_s      = (presc_r == (limit_s - PW'(1))) && !mode_press_s && !speed_press_s;
    next_mode_s = mode_r + 2'd1;
  end

  // Mode, speed, prescaler, breathe state and registered LED pattern.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r    <= MODE_ALT;
      speed_r   <= 2'd0;
      presc_r   <= {PW{1'b0}};
      duty_r    <= {PWM_BITS{1'b0}};
      dir_up_r  <= 1'b1;
      pwm_cnt_r <= {PWM_BITS{1'b0}};
      leds_r    <= seed_for(MODE_ALT);
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
      if (mode_press_s || speed_press_s || tick_s) begin
        presc_r <= {PW{1'b0}};
      end else begin
        presc_r <= presc_r + PW'(1);
      end
      if (speed_press_s) begin
        speed_r <= speed_r + 2'd1;
      end
      if (mode_press_s) begin
        mode_r   <= next_mode_s;
        leds_r   <= seed_for(next_mode_s);
        duty_r   <= {PWM_BITS{1'b0}};
        dir_up_r <= 1'b1;
      end else begin
        case (mode_r)
          MODE_ALT:   if (tick_s) leds_r <= ~leds_r;
          MODE_CHASE: if (tick_s) leds_r <= {leds_r[NUM_LEDS-2:0], leds_r[NUM_LEDS-1]};
          MODE_COUNT: if (tick_s) leds_r <= leds_r + NUM_LEDS'(1);
          MODE_BREATHE: begin
            leds_r <= {NUM_LEDS{(pwm_cnt_r < duty_r)}};
            // Turn around on reaching an endpoint so each endpoint is shown for one step.
            if (tick_s) begin
              if (dir_up_r) begin
                duty_r <= duty_r + PWM_BITS'(1);
                if (duty_r == (DUTY_MAX - PWM_BITS'(1))) dir_up_r <= 1'b0;
              end else begin
                duty_r <= duty_r - PWM_BITS'(1);
                if (duty_r == PWM_BITS'(1)) dir_up_r <= 1'b1;
              end
            end
          end
          default: leds_r <= leds_r;
        endcase
      end
    end
  end

  assign leds = leds_r;
  assign mode = mode_r;
endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random button activity, every cycle
// compared against a pattern model built from step counts rather than register images.

module tb_led_pattern_gen;
  localparam int NL = 4;
  localparam int SD = 16;
  localparam int DB = 4;
  localparam int PB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn_mode = 1'b0;
  logic          btn_speed = 1'b0;
  logic [NL-1:0] leds;
  logic [1:0]    mode;

  int errors = 0;
  int checks = 0;

  // model state
  int         m_mode, m_speed, m_cyc, m_steps, m_pwm;
  logic [3:0] exp_leds;
  logic [1:0] exp_mode;
  logic       s0 [2];
  logic       s1 [2];
  logic       lvl [2];
  logic [DB-1:0] hist [2];

  led_pattern_gen #(
    .NUM_LEDS(NL), .STEP_DIV(SD), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB)
  ) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_speed(btn_speed),
    .leds(leds), .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic int tri_duty(input int st);
    int p;
    p = st % 30;
    return (p <= 15) ? p : 30 - p;
  endfunction

  function automatic logic [3:0] pat(input int md, input int st);
    logic [3:0] v;
    case (md)
      0:       v = (st % 2 == 1) ? 4'b1010 : 4'b0101;
      1:       v = 4'(1 << (st % 4));
      2:       v = 4'(st % 16);
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_speed = 0; m_cyc = 0; m_steps = 0; m_pwm = 0;
    exp_leds = 4'b0101; exp_mode = 2'd0;
    for (int b = 0; b < 2; b++) begin
      s0[b] = 1'b0; s1[b] = 1'b0; lvl[b] = 1'b0; hist[b] = {DB{1'b0}};
    end
  endtask

  task automatic model_edge();
    logic press [2];
    logic raw [2];
    logic syncv;
    int period, pwm_old;
    bit tk, mp, sp;
    if (!rst) begin
      model_reset();
      return;
    end
    raw[0] = btn_mode;
    raw[1] = btn_speed;
    // a level is accepted once the last DB synchronised samples all disagree with it
    for (int b = 0; b < 2; b++) begin
      syncv = s1[b];
      s1[b] = s0[b];
      s0[b] = raw[b];
      hist[b] = {hist[b][DB-2:0], syncv};
      press[b] = 1'b0;
      if (hist[b] == (lvl[b] ? {DB{1'b0}} : {DB{1'b1}})) begin
        lvl[b] = ~lvl[b];
        press[b] = lvl[b];
      end
    end
    mp = press[0];
    sp = press[1];
    period = SD >> m_speed;
    tk = (m_cyc == period - 1) && !mp && !sp;
    pwm_old = m_pwm;
    m_pwm = (m_pwm + 1) % 16;
    if (mp || sp || tk) m_cyc = 0; else m_cyc++;
    if (sp) m_speed = (m_speed + 1) % 4;
    if (mp) begin
      m_mode = (m_mode + 1) % 4;
      m_steps = 0;
      exp_leds = pat(m_mode, 0);
    end else if (m_mode == 3) begin
      exp_leds = (pwm_old < tri_duty(m_steps)) ? 4'hF : 4'h0;
      if (tk) m_steps++;
    end else if (tk) begin
      m_steps++;
      exp_leds = pat(m_mode, m_steps);
    end
    exp_mode = 2'(m_mode);
  endtask

  task automatic check_outputs();
    checks++;
    assert (leds === exp_leds) else begin
      errors++;
      $error("FAIL leds observed=%b expected=%b t=%0t", leds, exp_leds, $time);
    end
    checks++;
    assert (mode === exp_mode) else begin
      errors++;
      $error("FAIL mode observed=%0d expected=%0d t=%0t", mode, exp_mode, $time);
    end
  endtask

  task automatic check_const(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick_clk();
  endtask

  task automatic press_mode();
    btn_mode = 1'b1; run(6);
    btn_mode = 1'b0; run(6);
  endtask

  task automatic press_speed();
    btn_speed = 1'b1; run(6);
    btn_speed = 1'b0; run(6);
  endtask

  initial begin
    model_reset();
    run(2);
    rst = 1'b1;
    check_const("reset_leds", leds, 4'b0101);
    check_const("reset_mode", {2'b00, mode}, 4'd0);
    run(16);
    check_const("alt_16", leds, 4'b1010);
    run(16);
    check_const("alt_32", leds, 4'b0101);
    run(32);

    // held button: exactly one mode advance
    btn_mode = 1'b1; run(10);
    check_const("hold_mode", {2'b00, mode}, 4'd1);
    btn_mode = 1'b0; run(70);

    // glitch and bounce are rejected
    btn_mode = 1'b1; run(2); btn_mode = 1'b0; run(20);
    check_const("glitch_mode", {2'b00, mode}, 4'd1);
    btn_mode = 1'b1; run(3); btn_mode = 1'b0; run(1);
    btn_mode = 1'b1; run(3); btn_mode = 1'b0; run(20);
    check_const("bounce_mode", {2'b00, mode}, 4'd1);

    // COUNT at speed 1, then wrap speed back to 0
    press_mode();
    check_const("count_mode", {2'b00, mode}, 4'd2);
    press_speed();
    run(140);
    press_speed(); press_speed(); press_speed();
    run(40);

    // BREATHE through a full triangle
    press_mode();
    check_const("breathe_mode", {2'b00, mode}, 4'd3);
    run(520);

    // back to COUNT, then async reset mid-pattern
    press_mode(); press_mode(); press_mode();
    run(37);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_const("async_leds", leds, 4'b0101);
    check_const("async_mode", {2'b00, mode}, 4'd0);
    run(2);
    rst = 1'b1;
    run(15);
    check_const("resume_15", leds, 4'b0101);
    run(1);
    check_const("resume_16", leds, 4'b1010);

    // random button activity
    for (int seg = 0; seg < 300; seg++) begin
      btn_mode  = 1'($urandom_range(0, 1));
      btn_speed = 1'($urandom_range(0, 1));
      run($urandom_range(1, 12));
    end
    btn_mode = 1'b0; btn_speed = 1'b0;
    run(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
